// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types, limits and the frame checksum helper for the UART command assembler.
package uart_cmd_pkg;

   localparam int unsigned MAX_OP_BYTES   = 4;
   localparam int unsigned MAX_OPS        = 4;
   localparam int unsigned MAX_FRAME_BITS = MAX_OPS * MAX_OP_BYTES * 8;

   typedef enum logic [3:0] {
      ST_RECV_OP  = 4'd0,
      ST_RECV_CMD = 4'd1,
      ST_RECV_CHK = 4'd2,
      ST_EXEC     = 4'd3,
      ST_TRIG     = 4'd4
   } state_e;

   // XOR of every operand byte and the command byte; unused upper lanes are zero.
   function automatic logic [7:0] xor_reduce_frame(input logic [MAX_FRAME_BITS-1:0] ops,
                                                   input logic [7:0]                cmd);
      logic [7:0] acc;
      acc = cmd;
      for (int unsigned i = 0; i < MAX_OPS * MAX_OP_BYTES; i++) begin
         acc = acc ^ ops[i*8 +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Receive-byte input and committed-frame output bundle of the UART command assembler.
interface uart_cmd_assembler_if #(
   parameter int unsigned OP_BYTES = 2,
   parameter int unsigned NUM_OPS  = 2
);
   localparam int unsigned DATA_W = 8 * OP_BYTES;

   logic                        rx_ready;
   logic [7:0]                  rx_data;
   logic [NUM_OPS*DATA_W-1:0]   operands;
   logic [7:0]                  cmd;
   logic                        frame_valid;
   logic                        tx_trigger;
   logic                        busy;
   logic                        timeout_err;
   logic                        chk_err;
   logic [3:0]                  state_dbg;

   modport master (
      output rx_ready, rx_data,
      input  operands, cmd, frame_valid, tx_trigger, busy, timeout_err, chk_err, state_dbg
   );

   modport slave (
      input  rx_ready, rx_data,
      output operands, cmd, frame_valid, tx_trigger, busy, timeout_err, chk_err, state_dbg
   );
endinterface

// File: rtl/uart_cmd_assembler_timer.sv
// Mid-frame idle watchdog: pulses expired on the TIMEOUT_CYCLES-th consecutive idle cycle.
module frame_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic kick,
   output logic expired
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // cnt holds the idle cycles already elapsed, so a kick in the expiry cycle still wins
   assign expired = !reset && run && !kick && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || !run || kick || expired) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/uart_cmd_assembler.sv
// Collects NUM_OPS operands plus a command byte from the UART and commits them atomically.
// Optional trailing XOR checksum byte enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_assembler
   import uart_cmd_pkg::*;
#(
   parameter int unsigned OP_BYTES       = 2,
   parameter int unsigned NUM_OPS        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_cmd_assembler_if.slave  bus
);
   localparam int unsigned DATA_W = 8 * OP_BYTES;
   localparam int unsigned OPS_W  = NUM_OPS * DATA_W;
   localparam int unsigned BCNT_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
   localparam int unsigned OCNT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(OP_BYTES - 1);
   localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(NUM_OPS - 1);

   state_e              state, state_nxt;
   logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
   logic [OCNT_W-1:0]   ocnt, ocnt_nxt;
   logic [OPS_W-1:0]    sh_ops, sh_ops_nxt;
   logic [7:0]          sh_cmd, sh_cmd_nxt;
   logic [OPS_W-1:0]    operands_q, operands_nxt;
   logic [7:0]          cmd_q, cmd_nxt;
   logic                frame_valid_q, frame_valid_nxt;
   logic                tx_trigger_q, tx_trigger_nxt;
   logic                busy_q, busy_nxt;
   logic                accept;
   logic                expired;
   logic                timer_run;
`ifdef UART_CMD_CHECKSUM_EN
   logic                chk_err_q, chk_err_nxt;
`endif

   // Bytes arriving while the frame is being committed are silently dropped
   assign accept    = bus.rx_ready && (state == ST_RECV_OP || state == ST_RECV_CMD ||
                                       state == ST_RECV_CHK);
   assign timer_run = busy_q && (state != ST_EXEC) && (state != ST_TRIG);

   frame_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .run    (timer_run),
      .kick   (accept),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RECV_OP;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      bcnt_nxt        = bcnt;
      ocnt_nxt        = ocnt;
      sh_ops_nxt      = sh_ops;
      sh_cmd_nxt      = sh_cmd;
      operands_nxt    = operands_q;
      cmd_nxt         = cmd_q;
      frame_valid_nxt = 1'b0;
      tx_trigger_nxt  = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_err_nxt     = 1'b0;
`endif

      case (state)
         ST_RECV_OP: begin
            if (accept) begin
               for (int unsigned o = 0; o < NUM_OPS; o++) begin
                  for (int unsigned b = 0; b < OP_BYTES; b++) begin
                     if (ocnt == OCNT_W'(o) && bcnt == BCNT_W'(b)) begin
                        sh_ops_nxt[(o*OP_BYTES + b)*8 +: 8] = bus.rx_data;
                     end
                  end
               end
               if (bcnt == BCNT_LAST) begin
                  bcnt_nxt = '0;
                  if (ocnt == OCNT_LAST) begin
                     ocnt_nxt  = '0;
                     state_nxt = ST_RECV_CMD;
                  end else begin
                     ocnt_nxt = ocnt + OCNT_W'(1);
                  end
               end else begin
                  bcnt_nxt = bcnt + BCNT_W'(1);
               end
            end
         end

         ST_RECV_CMD: begin
            if (accept) begin
               sh_cmd_nxt = bus.rx_data;
`ifdef UART_CMD_CHECKSUM_EN
               state_nxt  = ST_RECV_CHK;
`else
               state_nxt       = ST_EXEC;
               operands_nxt    = sh_ops;
               cmd_nxt         = bus.rx_data;
               frame_valid_nxt = 1'b1;
`endif
            end
         end

`ifdef UART_CMD_CHECKSUM_EN
         ST_RECV_CHK: begin
            if (accept) begin
               if (bus.rx_data == xor_reduce_frame(MAX_FRAME_BITS'(sh_ops), sh_cmd)) begin
                  state_nxt       = ST_EXEC;
                  operands_nxt    = sh_ops;
                  cmd_nxt         = sh_cmd;
                  frame_valid_nxt = 1'b1;
               end else begin
                  state_nxt   = ST_RECV_OP;
                  chk_err_nxt = 1'b1;
                  bcnt_nxt    = '0;
                  ocnt_nxt    = '0;
                  sh_ops_nxt  = '0;
                  sh_cmd_nxt  = '0;
               end
            end
         end
`endif

         ST_EXEC: begin
            state_nxt      = ST_TRIG;
            tx_trigger_nxt = 1'b1;
         end

         ST_TRIG: begin
            state_nxt = ST_RECV_OP;
            bcnt_nxt  = '0;
            ocnt_nxt  = '0;
         end

         default: begin
            state_nxt = ST_RECV_OP;
         end
      endcase

      // Timeout only fires in a cycle with no accepted byte, so it never races a commit
      if (expired) begin
         state_nxt  = ST_RECV_OP;
         bcnt_nxt   = '0;
         ocnt_nxt   = '0;
         sh_ops_nxt = '0;
         sh_cmd_nxt = '0;
      end

      busy_nxt = !(state_nxt == ST_RECV_OP && bcnt_nxt == '0 && ocnt_nxt == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt          <= '0;
         ocnt          <= '0;
         sh_ops        <= '0;
         sh_cmd        <= '0;
         operands_q    <= '0;
         cmd_q         <= '0;
         frame_valid_q <= 1'b0;
         tx_trigger_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         bcnt          <= bcnt_nxt;
         ocnt          <= ocnt_nxt;
         sh_ops        <= sh_ops_nxt;
         sh_cmd        <= sh_cmd_nxt;
         operands_q    <= operands_nxt;
         cmd_q         <= cmd_nxt;
         frame_valid_q <= frame_valid_nxt;
         tx_trigger_q  <= tx_trigger_nxt;
         busy_q        <= busy_nxt;
      end
   end

`ifdef UART_CMD_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         chk_err_q <= 1'b0;
      end else begin
         chk_err_q <= chk_err_nxt;
      end
   end
   assign bus.chk_err = chk_err_q;
`else
   assign bus.chk_err = 1'b0;
`endif

   assign bus.operands    = operands_q;
   assign bus.cmd         = cmd_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.tx_trigger  = tx_trigger_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = expired;
   assign bus.state_dbg   = state;
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler: a 2x2 instance (timeout 50) and a 3x3 instance.
module tb_uart_cmd_assembler;
   import uart_cmd_pkg::*;

   localparam int unsigned TO = 50;

   typedef enum int {EV_FRAME = 0, EV_TIMEOUT = 1, EV_CHK = 2} ev_e;
   typedef struct {
      ev_e          kind;
      longint       cyc;
      logic [127:0] ops;
      logic [7:0]   cmd;
      bit           trig;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   longint cyc = 0;
   int     checks = 0;
   int     failures = 0;
   exp_t   qa[$];
   exp_t   qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_cmd_assembler_if #(.OP_BYTES(2), .NUM_OPS(2)) bus_a ();
   uart_cmd_assembler_if #(.OP_BYTES(3), .NUM_OPS(3)) bus_b ();

   uart_cmd_assembler #(.OP_BYTES(2), .NUM_OPS(2), .TIMEOUT_CYCLES(TO)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   uart_cmd_assembler #(.OP_BYTES(3), .NUM_OPS(3), .TIMEOUT_CYCLES(TO)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for instance A
   logic [127:0] last_ops_a = '0;
   logic [7:0]   last_cmd_a = '0;
   bit           pend_a = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      ev_e  k;
      if (pend_a) check("tx_trigger_a", 128'(bus_a.tx_trigger), 128'(1));
      else if (bus_a.tx_trigger) check("stray_tx_trigger_a", 128'(bus_a.tx_trigger), 128'(0));
      pend_a = 1'b0;
      if (bus_a.frame_valid || bus_a.timeout_err || bus_a.chk_err) begin
         k = bus_a.frame_valid ? EV_FRAME : (bus_a.timeout_err ? EV_TIMEOUT : EV_CHK);
         if (qa.size() == 0) begin
            check("unexpected_event_a", 128'({bus_a.frame_valid, bus_a.timeout_err, bus_a.chk_err}), 128'(0));
         end else begin
            e = qa.pop_front();
            check("event_kind_a", 128'(k), 128'(e.kind));
            check("event_cycle_a", 128'(cyc), 128'(e.cyc));
            if (e.kind == EV_FRAME) begin
               check("operands_a", 128'(bus_a.operands), e.ops);
               check("cmd_a", 128'(bus_a.cmd), 128'(e.cmd));
               pend_a = e.trig;
            end else begin
               check("operands_kept_a", 128'(bus_a.operands), last_ops_a);
               check("cmd_kept_a", 128'(bus_a.cmd), 128'(last_cmd_a));
            end
            if (k == EV_FRAME) begin
               last_ops_a = e.ops;
               last_cmd_a = e.cmd;
            end
         end
      end
      if (reset) begin
         last_ops_a = '0;
         last_cmd_a = '0;
      end
   end

   // Monitor for instance B
   bit pend_b = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (pend_b) check("tx_trigger_b", 128'(bus_b.tx_trigger), 128'(1));
      else if (bus_b.tx_trigger) check("stray_tx_trigger_b", 128'(bus_b.tx_trigger), 128'(0));
      pend_b = 1'b0;
      if (bus_b.frame_valid || bus_b.timeout_err || bus_b.chk_err) begin
         if (qb.size() == 0 || !bus_b.frame_valid) begin
            check("unexpected_event_b", 128'({bus_b.frame_valid, bus_b.timeout_err, bus_b.chk_err}), 128'(4));
         end else begin
            e = qb.pop_front();
            check("event_cycle_b", 128'(cyc), 128'(e.cyc));
            check("operands_b", 128'(bus_b.operands), e.ops);
            check("cmd_b", 128'(bus_b.cmd), 128'(e.cmd));
            pend_b = e.trig;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_a(input logic [7:0] b, output longint t);
      bus_a.rx_ready = 1'b1;
      bus_a.rx_data  = b;
      t = cyc;
      @(posedge clk);
      #1;
      bus_a.rx_ready = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b, output longint t);
      bus_b.rx_ready = 1'b1;
      bus_b.rx_data  = b;
      t = cyc;
      @(posedge clk);
      #1;
      bus_b.rx_ready = 1'b0;
   endtask

   // Frame on A; gap idle cycles are inserted after the second byte
   task automatic send_frame_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input logic [7:0] c, input logic [31:0] exp_ops,
                               input bit trig, input int gap, output longint t);
      exp_t e;
      send_a(b0, t);
      send_a(b1, t);
      idle(gap);
      send_a(b2, t);
      send_a(b3, t);
      send_a(c, t);
`ifdef UART_CMD_CHECKSUM_EN
      send_a(b0 ^ b1 ^ b2 ^ b3 ^ c, t);
`endif
      e.kind = EV_FRAME; e.cyc = t + 1; e.ops = 128'(exp_ops); e.cmd = c; e.trig = trig;
      qa.push_back(e);
   endtask

   task automatic send_frame_b(input logic [7:0] first, input logic [7:0] c, input logic [71:0] exp_ops);
      exp_t       e;
      longint     t;
      logic [7:0] x;
      x = c;
      for (int i = 0; i < 9; i++) begin
         send_b(first + 8'(i), t);
         x = x ^ (first + 8'(i));
      end
      send_b(c, t);
`ifdef UART_CMD_CHECKSUM_EN
      send_b(x, t);
`endif
      e.kind = EV_FRAME; e.cyc = t + 1; e.ops = 128'(exp_ops); e.cmd = c; e.trig = 1'b1;
      qb.push_back(e);
   endtask

   task automatic check_all_zero_a(input string tag);
      check({tag, "_operands"}, 128'(bus_a.operands), 128'(0));
      check({tag, "_cmd"}, 128'(bus_a.cmd), 128'(0));
      check({tag, "_flags"}, 128'({bus_a.frame_valid, bus_a.tx_trigger, bus_a.busy,
                                   bus_a.timeout_err, bus_a.chk_err}), 128'(0));
      check({tag, "_state"}, 128'(bus_a.state_dbg), 128'(ST_RECV_OP));
   endtask

   initial begin
      longint t;
      exp_t   e;
      reset = 1'b1;
      bus_a.rx_ready = 1'b0; bus_a.rx_data = 8'h00;
      bus_b.rx_ready = 1'b0; bus_b.rx_data = 8'h00;
      idle(3);
      reset = 1'b0;
      check_all_zero_a("reset_a");
      check("reset_b_operands", 128'(bus_b.operands), 128'(0));
      check("reset_b_busy", 128'(bus_b.busy), 128'(0));
      idle(1);

      // Basic commit, then bytes in EXEC/TRIG must be dropped
      send_frame_a(8'h34, 8'h12, 8'h78, 8'h56, 8'h02, 32'h5678_1234, 1'b1, 0, t);
      idle(2);
      send_frame_a(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h03, 32'hDDCC_BBAA, 1'b1, 0, t);
      send_a(8'hEE, t);
      send_a(8'hFF, t);
      send_frame_a(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 32'h0403_0201, 1'b1, 0, t);
      idle(2);

      // Partial frame times out exactly TO cycles after its last byte
      send_a(8'h11, t);
      send_a(8'h22, t);
      e.kind = EV_TIMEOUT; e.cyc = t + TO; e.ops = '0; e.cmd = 8'h00; e.trig = 1'b0;
      qa.push_back(e);
      idle(TO + 5);
      send_frame_a(8'h21, 8'h43, 8'h65, 8'h87, 8'h09, 32'h8765_4321, 1'b1, 0, t);
      idle(2);

      // Byte arriving in the would-be expiry cycle wins
      send_frame_a(8'h11, 8'h22, 8'h33, 8'h44, 8'h06, 32'h4433_2211, 1'b1, TO - 1, t);
      idle(2);

      // Reset mid-frame
      send_a(8'h01, t);
      send_a(8'h02, t);
      send_a(8'h03, t);
      check("busy_mid_frame", 128'(bus_a.busy), 128'(1));
      check("state_mid_frame", 128'(bus_a.state_dbg), 128'(ST_RECV_OP));
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check_all_zero_a("midreset_a");
      send_frame_a(8'h10, 8'h20, 8'h30, 8'h40, 8'h07, 32'h4030_2010, 1'b1, 0, t);
      idle(1);
      send_a(8'h99, t);
      send_frame_a(8'h55, 8'h66, 8'h77, 8'h88, 8'h08, 32'h8877_6655, 1'b1, 0, t);
      idle(2);

      // Reset during EXEC suppresses tx_trigger
      send_frame_a(8'h01, 8'h23, 8'h45, 8'h67, 8'h0B, 32'h6745_2301, 1'b0, 0, t);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check_all_zero_a("execreset_a");
      idle(2);
      send_frame_a(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 1'b1, 0, t);
      idle(2);

`ifdef UART_CMD_CHECKSUM_EN
      // Wrong checksum discards the frame
      send_a(8'h34, t); send_a(8'h12, t); send_a(8'h78, t); send_a(8'h56, t);
      send_a(8'h02, t); send_a(8'h00, t);
      e.kind = EV_CHK; e.cyc = t + 1; e.ops = '0; e.cmd = 8'h00; e.trig = 1'b0;
      qa.push_back(e);
      idle(3);
      send_frame_a(8'h34, 8'h12, 8'h78, 8'h56, 8'h02, 32'h5678_1234, 1'b1, 0, t);
      idle(2);
`endif

      // Wider configuration on B
      send_frame_b(8'h01, 8'h0A, 72'h090807_060504_030201);
      idle(2);
      send_frame_b(8'hF0, 8'hFF, 72'hF8F7F6_F5F4F3_F2F1F0);
      idle(2);

      for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) idle(1);
      check("queue_a_drained", 128'(qa.size()), 128'(0));
      check("queue_b_drained", 128'(qb.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
